mw_countdown_timer: RTL and testbench

Keypad-loaded mm:ss countdown timer for the microwave controller. Accepts BCD digits in shift-left entry order and runs start/pause/clear control with door interlock. Decrements once per second while cooking. Its three BCD digit outputs feed the 7-segment driver stage directly (mins, sec_tens, sec_ones), and it flags cook-on and completion to the control level.

---
 rtl/mw_pkg.sv | 52 +++++
 rtl/mw_countdown_timer_tick_prescaler.sv | 32 +++
 rtl/mw_countdown_timer.sv | 111 +++++++++++
 tb/tb_mw_countdown_timer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mw_pkg.sv
// Shared types, constants and BCD helpers for the microwave countdown timer.
package mw_pkg;

  localparam int BCD_W = 4;

  localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [BCD_W-1:0] DIGIT_MAX    = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Displayed time as three BCD digits, m:ss.
  typedef struct packed {
    logic [BCD_W-1:0] mins;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] sec_ones;
  } mmss_t;

  function automatic logic is_zero(input mmss_t t);
    return (t == '0);
  endfunction

  // One-second BCD decrement with borrow through the tens and minutes digits.
  function automatic mmss_t bcd_dec(input mmss_t t);
    mmss_t r;
    r = t;
    if (t.sec_ones != '0) begin
      r.sec_ones = t.sec_ones - 1'b1;
    end else if (t.sec_tens != '0) begin
      r.sec_ones = DIGIT_MAX;
      r.sec_tens = t.sec_tens - 1'b1;
    end else if (t.mins != '0) begin
      r.mins     = t.mins - 1'b1;
      r.sec_tens = SEC_TENS_MAX;
      r.sec_ones = DIGIT_MAX;
    end
    return r;
  endfunction

  // Keypad entry: digits scroll in from the right.
  function automatic mmss_t shift_in(input mmss_t t, input logic [BCD_W-1:0] d);
    mmss_t r;
    r.mins     = t.sec_tens;
    r.sec_tens = t.sec_ones;
    r.sec_ones = d;
    return r;
  endfunction

endpackage

// File: rtl/mw_countdown_timer_tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  // A clear on the same cycle suppresses the tick so a restart never sees a stale second.
  assign tick = en && !clr && (count == CNT_MAX);

  // Count enabled cycles, wrapping on the tick; clear restarts the second.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/mw_countdown_timer.sv
// Keypad-loaded m:ss countdown timer with start/pause/clear and door interlock.
module mw_countdown_timer
  import mw_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [BCD_W-1:0] key_digit,
  input  logic             start,
  input  logic             stop,
  input  logic             door_open,
  output logic [BCD_W-1:0] mins,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             running,
  output logic             done
);

  state_t state, state_n;
  mmss_t  tm, tm_n;
  logic   done_n;
  logic   pre_clr;
  logic   tick;
  logic   start_ok;
  logic   key_ok;
  logic   halt;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clr  (pre_clr),
    .en   (state == RUN),
    .tick (tick)
  );

  assign start_ok = start && !door_open;
  assign halt     = stop || door_open;
  // A digit is taken only if the old ones digit can become a legal tens-of-seconds digit.
  assign key_ok   = key_valid && (key_digit <= DIGIT_MAX) && (tm.sec_ones <= SEC_TENS_MAX);

  // State, time and flag registers; running/done are registered copies of the next values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tm      <= '0;
      done    <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_n;
      tm      <= tm_n;
      done    <= done_n;
      running <= (state_n == RUN);
    end
  end

  // Next-state logic: stop/door outrank start, start outranks the tick.
  always_comb begin
    // NOTE: defaulting every combinational output first keeps this block latch-free.
    state_n = state;
    unique case (state)
      IDLE: begin
        if (!stop && start_ok && !is_zero(tm)) state_n = RUN;
      end
      RUN: begin
        if (halt)                               state_n = PAUSE;
        else if (tick && is_zero(bcd_dec(tm)))  state_n = IDLE;
      end
      PAUSE: begin
        if (stop)          state_n = IDLE;
        else if (start_ok) state_n = RUN;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath: time update, completion pulse and prescaler restart.
  always_comb begin
    tm_n    = tm;
    done_n  = 1'b0;
    pre_clr = 1'b0;
    unique case (state)
      IDLE: begin
        if (stop)                             tm_n    = '0;
        else if (start_ok && !is_zero(tm))    pre_clr = 1'b1;
        else if (key_ok)                      tm_n    = shift_in(tm, key_digit);
      end
      RUN: begin
        if (halt) begin
          pre_clr = 1'b1;
        end else if (tick) begin
          tm_n   = bcd_dec(tm);
          done_n = is_zero(bcd_dec(tm));
        end
      end
      PAUSE: begin
        if (stop)          tm_n    = '0;
        else if (start_ok) pre_clr = 1'b1;
      end
      default: tm_n = '0;
    endcase
  end

  assign mins     = tm.mins;
  assign sec_tens = tm.sec_tens;
  assign sec_ones = tm.sec_ones;

endmodule

// File: tb/tb_mw_countdown_timer.sv
// Scoreboard bench for mw_countdown_timer: model predicts each edge, monitor compares.
module tb_mw_countdown_timer;

  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       door_open = 1'b0;
  logic [3:0] mins, sec_tens, sec_ones;
  logic       running, done;

  typedef logic [13:0] vec_t;
  vec_t dut_vec;
  vec_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 run, 2 pause; time kept as digits, counted in seconds.
  int m_min = 0, m_ten = 0, m_one = 0;
  int m_phase = 0;
  int m_cycles = 0;
  bit m_done = 0;

  mw_countdown_timer #(.TICK_DIV(TICK_DIV)) dut (
    .clk      (clk),
    .reset    (rst),
    .key_valid(key_valid),
    .key_digit(key_digit),
    .start    (start),
    .stop     (stop),
    .door_open(door_open),
    .mins     (mins),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .running  (running),
    .done     (done)
  );

  always #5 clk = ~clk;

  assign dut_vec = {mins, sec_tens, sec_ones, running, done};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t model_vec();
    return {4'(m_min), 4'(m_ten), 4'(m_one), (m_phase == 1), m_done};
  endfunction

  function automatic int model_secs();
    return m_min * 60 + m_ten * 10 + m_one;
  endfunction

  task automatic model_clear();
    m_min = 0; m_ten = 0; m_one = 0;
  endtask

  // What the DUT should show after the coming edge, given these inputs.
  task automatic model_step(input bit r, kv, input int kd, input bit st, sp, dr);
    int s;
    m_done = 0;
    if (r) begin
      model_clear();
      m_phase  = 0;
      m_cycles = 0;
    end else begin
      case (m_phase)
        0: begin
          if (sp) model_clear();
          else if (st && !dr && model_secs() != 0) begin
            m_phase  = 1;
            m_cycles = 0;
          end else if (kv && kd <= 9 && m_one <= 5) begin
            m_min = m_ten; m_ten = m_one; m_one = kd;
          end
        end
        1: begin
          if (sp || dr) m_phase = 2;
          else begin
            m_cycles++;
            if (m_cycles == TICK_DIV) begin
              m_cycles = 0;
              s = model_secs() - 1;
              m_min = s / 60;
              m_ten = (s % 60) / 10;
              m_one = s % 10;
              if (s == 0) begin
                m_done  = 1;
                m_phase = 0;
              end
            end
          end
        end
        default: begin
          if (sp) begin
            model_clear();
            m_phase = 0;
          end else if (st && !dr) begin
            m_phase  = 1;
            m_cycles = 0;
          end
        end
      endcase
    end
  endtask

  task automatic step(input bit r, kv, input logic [3:0] kd, input bit st, sp, dr);
    @(negedge clk);
    rst = r; key_valid = kv; key_digit = kd; start = st; stop = sp; door_open = dr;
    model_step(r, kv, int'(kd), st, sp, dr);
    exp_q.push_back(model_vec());
  endtask

  task automatic press(input logic [3:0] d);
    step(0, 1, d, 0, 0, 0);
  endtask

  task automatic idle(input int n, input bit dr);
    for (int i = 0; i < n; i++) step(0, 0, 4'd0, 0, 0, dr);
  endtask

  // Direct check of the state the edge after the last step leaves behind.
  task automatic settle_check(input string name, input vec_t exp);
    @(posedge clk);
    #2;
    check(name, 32'(dut_vec), 32'(exp));
  endtask

  task automatic reset_mid();
    @(negedge clk);
    rst = 1; key_valid = 0; start = 0; stop = 0; door_open = 0;
    #1;
    check("async reset clears outputs", 32'(dut_vec), 32'd0);
    model_step(1, 0, 0, 0, 0, 0);
    exp_q.push_back(model_vec());
  endtask

  // Monitor: every edge, pop the prediction and compare against the DUT.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) check("mm:ss/running/done", 32'(dut_vec), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    bit dr_r;
    bit st_r, sp_r, kv_r, r_r;

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    settle_check("reset state", 14'd0);

    // Entry and the sec_ones > 5 rejection.
    press(1); press(3); press(0);
    settle_check("entry 1:30", {4'd1, 4'd3, 4'd0, 1'b0, 1'b0});
    step(0, 0, 0, 0, 1, 0);
    press(7); press(1);
    settle_check("entry 0:71 rejected", {4'd0, 4'd0, 4'd7, 1'b0, 1'b0});
    step(0, 0, 0, 0, 1, 0);

    // 0:12 countdown to completion.
    press(1); press(2);
    step(0, 0, 0, 1, 0, 0);
    settle_check("start running", {4'd0, 4'd1, 4'd2, 1'b1, 1'b0});
    idle(3, 0);
    step(0, 0, 0, 0, 0, 0);
    settle_check("first tick 0:11", {4'd0, 4'd1, 4'd1, 1'b1, 1'b0});
    idle(43, 0);
    step(0, 0, 0, 1, 0, 0);
    settle_check("done pulse at 0:00", {4'd0, 4'd0, 4'd0, 1'b0, 1'b1});
    step(0, 0, 0, 1, 0, 0);
    settle_check("no restart at 0:00", 14'd0);

    // Minute borrow 1:00 -> 0:59 -> 0:49.
    press(1); press(0); press(0);
    step(0, 0, 0, 1, 0, 0);
    idle(3, 0);
    step(0, 0, 0, 0, 0, 0);
    settle_check("borrow 0:59", {4'd0, 4'd5, 4'd9, 1'b1, 1'b0});
    idle(39, 0);
    step(0, 0, 0, 0, 0, 0);
    settle_check("tens borrow 0:49", {4'd0, 4'd4, 4'd9, 1'b1, 1'b0});
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    // Door interlock pause and resume.
    press(3); press(0);
    step(0, 0, 0, 1, 0, 0);
    idle(5, 0);
    step(0, 0, 0, 0, 0, 1);
    settle_check("door pause 0:29", {4'd0, 4'd2, 4'd9, 1'b0, 1'b0});
    idle(5, 1);
    step(0, 0, 0, 1, 0, 1);
    settle_check("start blocked by door", {4'd0, 4'd2, 4'd9, 1'b0, 1'b0});
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(3, 0);
    step(0, 0, 0, 0, 0, 0);
    settle_check("resume tick 0:28", {4'd0, 4'd2, 4'd8, 1'b1, 1'b0});
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    // Start at 0:00, stop in pause, start+stop in idle.
    step(0, 0, 0, 1, 0, 0);
    settle_check("start at 0:00 ignored", 14'd0);
    press(2); press(5);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    settle_check("stop in pause clears", 14'd0);
    press(4);
    step(0, 0, 0, 1, 1, 0);
    settle_check("start+stop in idle", 14'd0);

    // Reset in the middle of a run, then normal operation.
    press(4); press(2);
    step(0, 0, 0, 1, 0, 0);
    idle(2, 0);
    reset_mid();
    step(1, 0, 0, 0, 0, 0);
    press(5);
    step(0, 0, 0, 1, 0, 0);
    idle(25, 0);

    // Randomized traffic; keys only arrive on otherwise quiet cycles.
    dr_r = 0;
    for (int n = 0; n < 3000; n++) begin
      r_r  = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 59) == 0) dr_r = ~dr_r;
      st_r = ($urandom_range(0, 7) == 0);
      sp_r = ($urandom_range(0, 29) == 0);
      kv_r = !st_r && !sp_r && !dr_r && ($urandom_range(0, 2) == 0);
      step(r_r, kv_r, 4'($urandom_range(0, 15)), st_r, sp_r, dr_r);
    end
    step(0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
